egress_rr_sched: RTL
====================

# egress_rr_sched

Frame-level round-robin scheduler for one switch egress port. It grants the shared egress datapath to one of `N_REQ` output queues and holds that grant for a whole frame. The grant is released on the frame's last accepted beat, or by a stall watchdog. An inter-frame gap is then enforced before the next arbitration. It sits between the per-port queue managers and the egress MAC mux, and drives the mux select.

## Interface
- `N_REQ`, 8: number of requesting queues, ≥2, need not be a power of two.
- `N_REQ_L2`, `$clog2(N_REQ)`: index width.
- `GAP_CYC`, 2: idle cycles forced after each frame, ≥0.
- `TMO_W`, 16: watchdog counter/config width.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  asynchronous active-low reset.
- `req_vec`  in  N_REQ  level; bit i = queue i holds a complete frame.
- `sched_en`  in  1  0 = issue no new grants; a frame already in progress still completes.
- `frm_valid`, `frm_ready`, `frm_last`  in  1 each  egress beat handshake, as observed at the mux output.
- `cfg_tmo`  in  TMO_W  stall limit in cycles; 0 = watchdog disabled.
- `gnt_vec`  out  N_REQ  registered one-hot grant.
- `gnt_bin`  out  N_REQ_L2  registered binary index of the grant.
- `gnt_valid`  out  1  a grant is active.
- `tmo_pulse`  out  1  one-cycle pulse when a frame is aborted by the watchdog.

## Operation
- States: IDLE, BUSY, GAP. The state resets to IDLE.
- Reset values:
  - `gnt_vec`=0, `gnt_bin`=0, `gnt_valid`=0, `tmo_pulse`=0.
  - Pointer `ptr`=N_REQ-1, so the first grant goes to the lowest-index requester.
  - Gap and watchdog counters = 0.
- Arbitration is evaluated combinationally in IDLE only:
  - `mask` = bits with index > `ptr`.
  - If `req_vec & mask` ≠ 0, the winner is the lowest set index of `req_vec & mask`.
  - Otherwise the winner is the lowest set index of `req_vec`.
  - The result is exact round-robin.
- IDLE → BUSY when `sched_en` & |`req_vec`. At that edge, register `gnt_vec`/`gnt_bin`, set `gnt_valid`=1, and clear the watchdog counter.
- BUSY behaviour:
  - Grant outputs are frozen. `req_vec` and `sched_en` changes are ignored.
  - A beat is accepted when `frm_valid & frm_ready`.
  - An accepted beat with `frm_last` ends the frame.
  - Watchdog: the counter clears on every accepted beat and increments on every cycle without one.
  - If `cfg_tmo`≠0 and the counter equals `cfg_tmo`-1 in a cycle with no accepted beat, the frame is aborted.
- End of frame or abort, at the same edge:
  - `gnt_valid`=0 and `gnt_vec`=0; `gnt_bin` keeps its last value.
  - `ptr`←`gnt_bin`.
  - On abort only, `tmo_pulse`=1 for the next cycle.
  - Next state is GAP if `GAP_CYC`>0, else IDLE.
- GAP: the gap counter counts 0..`GAP_CYC`-1, then the state goes to IDLE. Requests are not sampled.
- Beats outside BUSY are ignored. `frm_last` without `frm_valid & frm_ready` is ignored.
- If a last beat and a watchdog expiry coincide, the last beat wins and no `tmo_pulse` is generated.
- If the granted queue drops its request during BUSY, the grant is still held until end of frame or timeout.
- Reset mid-frame: all state and outputs return to reset values immediately (asynchronous). There is no partial-frame recovery.

## Timing
- Grant latency: requests present in IDLE at cycle t → `gnt_valid`=1 at t+1.
- Gap between frames: last beat accepted at t → `gnt_valid` low at t+1 through t+GAP_CYC+1. The next grant is at t+GAP_CYC+2 at the earliest.
- Watchdog: grant at cycle g with no beats → `gnt_valid` low and `tmo_pulse` high at g+`cfg_tmo`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- The shared package holds:
  - the state encoding (IDLE/BUSY/GAP);
  - the `N_REQ_L2` derivation;
  - the mask-generation function (index > ptr → vector).
- Sub-module: reuse `rnd_rb_scal`, two instances, both with `rr_priority` tied to 0 so each acts as a lowest-index finder.
  - One instance takes `req_vec & mask`.
  - The other takes `req_vec`.
  - Select with |(`req_vec & mask`).
- The FSM, `ptr`, gap counter and watchdog live in the top module.

## Test plan
Configuration for all scenarios: N_REQ=4, GAP_CYC=2, one-beat frames unless stated.
- Reset, then `req_vec`=0b1010 at cycle 0 → cycle 1: `gnt_vec`=0b0010, `gnt_bin`=1, `gnt_valid`=1.
- `req_vec`=0b1111 held, each frame 3 beats → grant order 0,1,2,3,0, with `gnt_valid` low exactly 3 cycles between frames.
- `req_vec`=0b0101 held → grant order 0,2,0,2; queues 1 and 3 are never granted.
- `cfg_tmo`=5, grant at cycle 1, no beats → cycle 6: `tmo_pulse`=1, `gnt_valid`=0; the next grant goes to the next requester after the aborted index. Repeat with a last beat at cycle 5 → no pulse.
- Grant to queue 1, then `req_vec` drops to 0b1000 and `sched_en`=0 mid-frame → grant holds until `frm_last`, then no grant until `sched_en`=1, which yields grant 3.
- Assert `rstn` low mid-BUSY → all outputs 0 in the same cycle. After release with `req_vec`=0b1111 → grant 0.

Source files
------------

// File: rtl/egress_rr_sched_pkg.sv
// Shared types and helpers for the egress round-robin frame scheduler.
package egress_rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One bit of the round-robin mask: queues strictly above the last grant get first pick.
    function automatic logic above_ptr(input int idx, input int ptr);
        return idx > ptr;
    endfunction

endpackage

// File: rtl/rnd_rb_scal.sv
// Combinational one-hot picker: lowest set index when rr_priority_i is 0, highest when 1.
module rnd_rb_scal #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic             rr_priority_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        if (!rr_priority_i) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    gnt_o    = '0;
                    gnt_o[i] = 1'b1;
                    idx_o    = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_i[i]) begin
                    gnt_o    = '0;
                    gnt_o[i] = 1'b1;
                    idx_o    = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/egress_rr_sched.sv
// Frame-level round-robin scheduler for one egress port: holds a grant for a whole
// frame, releases on last beat or stall watchdog, then enforces an inter-frame gap.
module egress_rr_sched
    import egress_rr_sched_pkg::*;
#(
    parameter int N_REQ    = 8,
    parameter int N_REQ_L2 = idx_width(N_REQ),
    parameter int GAP_CYC  = 2,
    parameter int TMO_W    = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req_vec,
    input  logic                sched_en,
    input  logic                frm_valid,
    input  logic                frm_ready,
    input  logic                frm_last,
    input  logic [TMO_W-1:0]    cfg_tmo,
    output logic [N_REQ-1:0]    gnt_vec,
    output logic [N_REQ_L2-1:0] gnt_bin,
    output logic                gnt_valid,
    output logic                tmo_pulse
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    sched_state_e        state_q;
    logic [N_REQ_L2-1:0] ptr_q;
    logic [GAP_W-1:0]    gap_q;
    logic [TMO_W-1:0]    wdog_q, wdog_d;
    logic [N_REQ-1:0]    gnt_vec_q;
    logic [N_REQ_L2-1:0] gnt_bin_q;
    logic                gnt_valid_q, tmo_pulse_q;

    logic [N_REQ-1:0]    mask, req_masked, win_masked_vec, win_all_vec, win_vec;
    logic [N_REQ_L2-1:0] win_masked_bin, win_all_bin, win_bin;
    logic                any_masked, any_req;
    logic                beat_acc, beat_last, wdog_hit;

    always_comb begin
        mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = above_ptr(i, int'(ptr_q));
        end
    end

    assign req_masked = req_vec & mask;

    rnd_rb_scal #(.N(N_REQ), .IDX_W(N_REQ_L2)) u_pick_masked (
        .req_i         (req_masked),
        .rr_priority_i (1'b0),
        .gnt_o         (win_masked_vec),
        .idx_o         (win_masked_bin),
        .any_o         (any_masked)
    );

    rnd_rb_scal #(.N(N_REQ), .IDX_W(N_REQ_L2)) u_pick_all (
        .req_i         (req_vec),
        .rr_priority_i (1'b0),
        .gnt_o         (win_all_vec),
        .idx_o         (win_all_bin),
        .any_o         (any_req)
    );

    assign win_vec = any_masked ? win_masked_vec : win_all_vec;
    assign win_bin = any_masked ? win_masked_bin : win_all_bin;

    // A last beat takes precedence over a coinciding watchdog expiry.
    assign beat_acc  = frm_valid & frm_ready;
    assign beat_last = beat_acc & frm_last;
    assign wdog_hit  = (cfg_tmo != '0) && !beat_acc && (wdog_q == cfg_tmo - 1'b1);
    assign wdog_d    = beat_acc ? '0 : wdog_q + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            ptr_q       <= N_REQ_L2'(N_REQ - 1);
            gap_q       <= '0;
            wdog_q      <= '0;
            gnt_vec_q   <= '0;
            gnt_bin_q   <= '0;
            gnt_valid_q <= 1'b0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sched_en && any_req) begin
                        gnt_vec_q   <= win_vec;
                        gnt_bin_q   <= win_bin;
                        gnt_valid_q <= 1'b1;
                        wdog_q      <= '0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    wdog_q <= wdog_d;
                    if (beat_last || wdog_hit) begin
                        gnt_vec_q   <= '0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= gnt_bin_q;
                        tmo_pulse_q <= !beat_last;
                        gap_q       <= '0;
                        state_q     <= (GAP_CYC > 0) ? ST_GAP : ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt_vec   = gnt_vec_q;
    assign gnt_bin   = gnt_bin_q;
    assign gnt_valid = gnt_valid_q;
    assign tmo_pulse = tmo_pulse_q;

endmodule
